mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: formats loads/stores for a ready-handshaked data bus,
// flags misaligned accesses and stalls the pipeline until the bus transaction completes.
module mem_access #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] mem_pc,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_alures,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  mem_wraddr,
    input  logic        mem_wreg,
    output logic [31:0] out_memdata,
    output logic        out_wreg,
    output logic        stallreq,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr,
    output logic        dbus_en,
    output logic [3:0]  dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ready
);

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic [31:0] load_fmt(input logic [7:0] op, input logic [1:0] bl,
                                             input logic hl, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{bl, 3'b000} +: 8];
        h = w[{hl, 4'b0000} +: 16];
        case (op)
            OP_LB:   load_fmt = {{24{b[7]}}, b};
            OP_LBU:  load_fmt = {24'h0, b};
            OP_LH:   load_fmt = {{16{h[15]}}, h};
            OP_LHU:  load_fmt = {16'h0, h};
            OP_LW:   load_fmt = w;
            default: load_fmt = 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] store_wen(input logic [7:0] op, input logic [1:0] bl,
                                             input logic hl);
        case (op)
            OP_SB:   store_wen = 4'b0001 << bl;
            OP_SH:   store_wen = hl ? 4'b1100 : 4'b0011;
            OP_SW:   store_wen = 4'b1111;
            default: store_wen = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   store_data = {4{wd[7:0]}};
            OP_SH:   store_data = {2{wd[15:0]}};
            OP_SW:   store_data = wd;
            default: store_data = 32'h0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  bl_q, bl_d;
    logic        hl_q, hl_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;

    logic        is_load, is_store, is_half, is_word, misalign;
    logic [1:0]  bl;
    logic        hl;
    logic        unused_inputs;

    assign unused_inputs = ^{mem_pc, mem_wraddr};

    assign is_load  = (mem_aluop == OP_LB) || (mem_aluop == OP_LBU) || (mem_aluop == OP_LH) ||
                      (mem_aluop == OP_LHU) || (mem_aluop == OP_LW);
    assign is_store = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
    assign is_half  = (mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH);
    assign is_word  = (mem_aluop == OP_LW) || (mem_aluop == OP_SW);
    assign misalign = (is_half && mem_alures[0]) || (is_word && (mem_alures[1:0] != 2'b00));
    // Lane indices are mirrored for a big-endian bus
    assign bl       = BIG_ENDIAN ? ~mem_alures[1:0] : mem_alures[1:0];
    assign hl       = BIG_ENDIAN ? ~mem_alures[1] : mem_alures[1];

    // Next-state, request capture and output decode
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        op_d        = op_q;
        bl_d        = bl_q;
        hl_d        = hl_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        out_memdata = 32'h0;
        out_wreg    = mem_wreg;
        stallreq    = 1'b0;
        exc_adel    = 1'b0;
        exc_ades    = 1'b0;
        badvaddr    = 32'h0;
        dbus_en     = 1'b0;
        dbus_wen    = 4'h0;
        dbus_addr   = 32'h0;
        dbus_wdata  = 32'h0;
        if (rst) begin
            state_d  = S_IDLE;
            buf_d    = 32'h0;
            out_wreg = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        out_wreg = 1'b0;
                    end else if ((is_load || is_store) && misalign) begin
                        exc_adel = is_load;
                        exc_ades = is_store;
                        badvaddr = mem_alures;
                        out_wreg = 1'b0;
                    end else if (is_load || is_store) begin
                        op_d       = mem_aluop;
                        bl_d       = bl;
                        hl_d       = hl;
                        addr_d     = {mem_alures[31:2], 2'b00};
                        wen_d      = store_wen(mem_aluop, bl, hl);
                        wdata_d    = store_data(mem_aluop, mem_wdata);
                        dbus_en    = 1'b1;
                        dbus_addr  = addr_d;
                        dbus_wen   = wen_d;
                        dbus_wdata = wdata_d;
                        stallreq   = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    dbus_en    = 1'b1;
                    dbus_addr  = addr_q;
                    dbus_wen   = wen_q;
                    dbus_wdata = wdata_q;
                    stallreq   = 1'b1;
                    if (flush) begin
                        out_wreg = 1'b0;
                        state_d  = dbus_ready ? S_IDLE : S_DRAIN;
                    end else if (dbus_ready) begin
                        buf_d   = dbus_rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DONE: begin
                    out_memdata = load_fmt(op_q, bl_q, hl_q, buf_q);
                    if (flush) begin
                        out_wreg = 1'b0;
                        state_d  = S_IDLE;
                    end else if (!stall) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DRAIN: begin
                    // The flushed request must still complete on the bus; its data is dropped
                    dbus_en    = 1'b1;
                    dbus_addr  = addr_q;
                    dbus_wen   = wen_q;
                    dbus_wdata = wdata_q;
                    stallreq   = 1'b1;
                    out_wreg   = 1'b0;
                    if (dbus_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, captured request and read buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= 32'h0;
            op_q    <= 8'h0;
            bl_q    <= 2'b00;
            hl_q    <= 1'b0;
            addr_q  <= 32'h0;
            wen_q   <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            op_q    <= op_d;
            bl_q    <= bl_d;
            hl_q    <= hl_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected bus handshakes and exceptions,
// a forked monitor pops and compares whenever the DUT presents one.
module tb_mem_access;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        logic        adel;
        logic        ades;
        logic [31:0] bad;
    } exc_exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_wreg, dbus_ready;
    logic [31:0] mem_pc, mem_alures, mem_wdata, dbus_rdata;
    logic [7:0]  mem_aluop;
    logic [4:0]  mem_wraddr;
    logic [31:0] out_memdata, badvaddr, dbus_addr, dbus_wdata;
    logic        out_wreg, stallreq, exc_adel, exc_ades, dbus_en;
    logic [3:0]  dbus_wen;

    bus_exp_t bus_q[$];
    exc_exp_t exc_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access #(.BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_pc(mem_pc), .mem_aluop(mem_aluop), .mem_alures(mem_alures),
        .mem_wdata(mem_wdata), .mem_wraddr(mem_wraddr), .mem_wreg(mem_wreg),
        .out_memdata(out_memdata), .out_wreg(out_wreg), .stallreq(stallreq),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr),
        .dbus_en(dbus_en), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ready(dbus_ready)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        bus_exp_t    be;
        exc_exp_t    ee;
        logic        pend;
        logic [31:0] pend_data;
        pend = 1'b0;
        pend_data = 32'h0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk32("done_stallreq", {31'h0, stallreq}, 32'h0);
                chk32("done_memdata", out_memdata, pend_data);
                pend = 1'b0;
            end
            if (dbus_en && dbus_ready) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: addr 0x%08h, expected no request", dbus_addr);
                end else begin
                    be = bus_q.pop_front();
                    chk32("bus_addr", dbus_addr, be.addr);
                    chk32("bus_wen", {28'h0, dbus_wen}, {28'h0, be.wen});
                    if (be.chk_wdata) chk32("bus_wdata", dbus_wdata, be.wdata);
                    pend = 1'b1;
                    pend_data = be.data;
                end
            end
            if (exc_adel || exc_ades) begin
                if (exc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exc: badvaddr 0x%08h, expected none", badvaddr);
                end else begin
                    ee = exc_q.pop_front();
                    chk32("exc_flags", {30'h0, exc_adel, exc_ades}, {30'h0, ee.adel, ee.ades});
                    chk32("exc_badvaddr", badvaddr, ee.bad);
                    chk32("exc_quiet", {29'h0, dbus_en, stallreq, out_wreg}, 32'h0);
                end
            end
        end
    endtask

    task automatic set_nop(input logic wreg);
        mem_aluop  = OP_NOP;
        mem_alures = 32'h0;
        mem_wdata  = 32'h0;
        mem_wreg   = wreg;
        flush      = 1'b0;
        stall      = 1'b0;
        dbus_ready = 1'b0;
    endtask

    // Issues one aligned op; ready goes high after lo wait cycles; DONE is held for hold extra cycles.
    task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] e_addr, input logic [3:0] e_wen,
                          input logic [31:0] e_wdata, input logic chkw, input logic [31:0] e_data,
                          input int lo, input int hold);
        bus_exp_t be;
        int cnt;
        be.addr = e_addr; be.wen = e_wen; be.wdata = e_wdata; be.chk_wdata = chkw; be.data = e_data;
        bus_q.push_back(be);
        mem_aluop = op; mem_alures = addr; mem_wdata = wd; dbus_rdata = rd;
        mem_wreg = 1'b1; stall = (hold > 0);
        cnt = 0;
        for (int k = 0; k <= lo + 1; k++) begin
            dbus_ready = (k == lo + 1);
            @(negedge clk);
            if (stallreq) cnt++;
            @(posedge clk); #1;
        end
        dbus_ready = 1'b0;
        dbus_rdata = ~rd;
        chk32("stall_cycles", cnt, lo + 2);
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) set_nop(1'b1);
            @(negedge clk);
            if (h > 0) chk32("hold_memdata", out_memdata, e_data);
            @(posedge clk); #1;
        end
    endtask

    task automatic exc_op(input logic [7:0] op, input logic [31:0] addr, input logic adel,
                          input logic ades);
        exc_exp_t ee;
        ee.adel = adel; ee.ades = ades; ee.bad = addr;
        exc_q.push_back(ee);
        mem_aluop = op; mem_alures = addr; mem_wdata = 32'h5555_AAAA; mem_wreg = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        set_nop(1'b1);
    endtask

    initial begin
        int cnt;
        bus_exp_t be;
        fork
            monitor();
        join_none
        mem_pc = 32'h0000_1000; mem_wraddr = 5'd3; dbus_rdata = 32'h0;
        set_nop(1'b1);
        rst = 1'b1;
        mem_aluop = OP_LW; mem_alures = 32'h0000_0100;
        @(posedge clk); #1;
        @(negedge clk);
        chk32("rst_ctrl", {26'h0, dbus_en, stallreq, out_wreg, exc_adel, exc_ades, 1'b0}, 32'h0);
        chk32("rst_wen", {28'h0, dbus_wen}, 32'h0);
        chk32("rst_memdata", out_memdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop(1'b1);
        @(negedge clk);
        chk32("nop_pass", {29'h0, out_wreg, dbus_en, stallreq}, 32'h4);
        chk32("nop_memdata", out_memdata, 32'h0);
        @(posedge clk); #1;

        mem_op(OP_LW,  32'h100, 32'h0, 32'hDEAD_BEEF, 32'h100, 4'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 0);
        mem_op(OP_LB,  32'h103, 32'h0, 32'h80FF_1234, 32'h100, 4'h0, 32'h0, 1'b0, 32'hFFFF_FF80, 0, 0);
        mem_op(OP_LBU, 32'h103, 32'h0, 32'h80FF_1234, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0000_0080, 2, 0);
        mem_op(OP_LH,  32'h102, 32'h0, 32'h80FF_1234, 32'h100, 4'h0, 32'h0, 1'b0, 32'hFFFF_80FF, 0, 0);
        mem_op(OP_LHU, 32'h100, 32'h0, 32'h80FF_1234, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0000_1234, 0, 0);
        mem_op(OP_SH,  32'h202, 32'h0000_ABCD, 32'h0, 32'h200, 4'hC, 32'hABCD_ABCD, 1'b1, 32'h0, 0, 0);
        mem_op(OP_SB,  32'h201, 32'h1234_5678, 32'h0, 32'h200, 4'h2, 32'h7878_7878, 1'b1, 32'h0, 1, 0);
        mem_op(OP_SW,  32'h204, 32'hCAFE_F00D, 32'h0, 32'h204, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0, 0, 0);

        exc_op(OP_LW, 32'h101, 1'b1, 1'b0);
        exc_op(OP_SH, 32'h203, 1'b0, 1'b1);
        exc_op(OP_SW, 32'h206, 1'b0, 1'b1);
        exc_op(OP_LH, 32'h101, 1'b1, 1'b0);

        // Flush during WAIT, ready arrives on the third DRAIN cycle
        be.addr = 32'h400; be.wen = 4'h0; be.wdata = 32'h0; be.chk_wdata = 1'b0; be.data = 32'h0;
        bus_q.push_back(be);
        mem_aluop = OP_LW; mem_alures = 32'h400; mem_wreg = 1'b1; dbus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk32("flush_wait_wreg", {31'h0, out_wreg}, 32'h0);
        @(posedge clk); #1;
        set_nop(1'b1);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            dbus_ready = (k == 2);
            @(negedge clk);
            if (stallreq && dbus_en && !out_wreg) cnt++;
            @(posedge clk); #1;
        end
        dbus_ready = 1'b0;
        chk32("drain_cycles", cnt, 32'd3);
        @(negedge clk);
        chk32("after_drain", {30'h0, dbus_en, out_wreg}, 32'h1);
        @(posedge clk); #1;

        // Flush and ready in the same WAIT cycle: data discarded
        be.addr = 32'h500; be.data = 32'h0;
        bus_q.push_back(be);
        mem_aluop = OP_LW; mem_alures = 32'h500; dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1; dbus_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        set_nop(1'b1);
        @(negedge clk);
        chk32("flushrdy_idle", {31'h0, dbus_en}, 32'h0);
        @(posedge clk); #1;

        // DONE held by stall, then reset in the middle of the next load's WAIT
        mem_op(OP_LW, 32'h300, 32'h0, 32'h1122_3344, 32'h300, 4'h0, 32'h0, 1'b0, 32'h1122_3344, 0, 2);
        mem_aluop = OP_LW; mem_alures = 32'h304; mem_wreg = 1'b0;
        @(negedge clk);
        chk32("rstwait_issue", {31'h0, dbus_en}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk32("rstwait_ctrl", {27'h0, dbus_en, stallreq, out_wreg, exc_adel, exc_ades}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop(1'b0);
        dbus_ready = 1'b1;
        @(negedge clk);
        chk32("late_ready_ctrl", {27'h0, dbus_en, stallreq, out_wreg, exc_adel, exc_ades}, 32'h0);
        chk32("late_ready_bus", {dbus_wen, dbus_addr[27:0]}, 32'h0);
        @(posedge clk); #1;
        dbus_ready = 1'b0;
        @(negedge clk);
        chk32("late_ready_after", {31'h0, stallreq}, 32'h0);
        chk32("late_ready_memdata", out_memdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);

        chk32("bus_q_empty", bus_q.size(), 32'd0);
        chk32("exc_q_empty", exc_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
